flag_rename_table: RTL and testbench
====================================

FLAG_RENAME_TABLE -- requirements
Module: flag_rename_table

Interface
REQ-001 Parameters SHALL be: ENTRY_N, default 16, number of flag rename entries (power of 2, 2..64); TAG_W, default 6, commit tag width; FLAG_W, default 5, flag width; CDB_N, default 2, result channel count (1..4); IDX_W, default $clog2(ENTRY_N), entry index width.
REQ-002 Ports SHALL be, in this order:
- iCLOCK  in  1  sole clock, rising edge.
- inRESET  in  1  asynchronous, active-low reset.
- iREMOVE_VALID  in  1  pipeline flush.
- iCOMMIT_VECTOR  in  2**TAG_W  per-tag commit strobes.
- iREGIST_0_VALID / iREGIST_1_VALID  in  1 each  allocation requests.
- iREGIST_0_COMMIT_TAG / iREGIST_1_COMMIT_TAG  in  TAG_W each  producer tags.
- oREGIST_0_REGNAME / oREGIST_1_REGNAME  out  IDX_W each  entry granted to each port.
- oREGIST_0_READY / oREGIST_1_READY  out  1 each  at least 1 / at least 2 entries free.
- iCDB_VALID  in  CDB_N  result-channel valids.
- iCDB_COMMIT_TAG  in  CDB_N*TAG_W  channel c at bits [c*TAG_W +: TAG_W].
- iCDB_FLAGS  in  CDB_N*FLAG_W  channel c at bits [c*FLAG_W +: FLAG_W].
- iQUERY_REGNAME  in  IDX_W  lookup index.
- oQUERY_FLAGS_VALID  out  1  queried entry holds valid flags.
- oQUERY_FLAGS  out  FLAG_W  queried entry's flags.
- oINFO_FREE_COUNT  out  IDX_W+1  number of entries in FREE.

Function
REQ-003 Each entry SHALL hold a registered state, a TAG_W tag and FLAG_W flags; states FREE, WAIT, DONE, RELEASE.
REQ-004 oREGIST_0_REGNAME SHALL be the lowest-index FREE entry and oREGIST_1_REGNAME the second-lowest, both combinational from registered state; when no such entry exists the output is 0.
REQ-005 oREGIST_0_READY SHALL be high when free count >= 1; oREGIST_1_READY SHALL be high when free count >= 2.
REQ-006 A request is granted only when its port's VALID and READY are both high and iREMOVE_VALID is low.
REQ-007 iREGIST_1_VALID SHALL be ignored unless iREGIST_0_VALID is also high.
REQ-008 On grant, the granted entry SHALL go FREE->WAIT next cycle, latching its port's COMMIT_TAG; flags are unchanged.
REQ-009 In WAIT, if some channel c has iCDB_VALID[c] high and a tag equal to the entry tag, the entry SHALL go to DONE and latch that channel's flags; when several channels match, the lowest c wins.
REQ-010 In DONE, when iCOMMIT_VECTOR[(tag+1) mod 2**TAG_W] is high, the entry SHALL go to RELEASE; RELEASE SHALL go to FREE unconditionally on the next cycle.
REQ-011 iREMOVE_VALID high SHALL move every WAIT entry to FREE next cycle; the flush takes priority over any same-cycle CDB match.
REQ-012 DONE and RELEASE entries SHALL be unaffected by iREMOVE_VALID; a same-cycle commit still applies.
REQ-013 Entries freed in cycle N (RELEASE->FREE or flush) SHALL NOT be granted before cycle N+1.
REQ-014 oQUERY_FLAGS_VALID SHALL be 1 when the indexed entry is in DONE, and 0 otherwise (including RELEASE).
REQ-015 oQUERY_FLAGS SHALL be the indexed entry's stored flags, combinational, with no CDB bypass.
REQ-016 oINFO_FREE_COUNT SHALL equal the number of FREE entries from registered state.
REQ-017 Tag comparison SHALL be full TAG_W equality; the commit index wraps modulo 2**TAG_W, so tag 2**TAG_W-1 checks bit 0.
REQ-018 CDB results for tags held by no WAIT entry SHALL be ignored without any state change.

Reset
REQ-019 When inRESET is low, every entry SHALL asynchronously go to FREE with tag 0 and flags 0.
REQ-020 After reset, outputs SHALL be: oINFO_FREE_COUNT=ENTRY_N, oREGIST_0_REGNAME=0, oREGIST_1_REGNAME=1, both READY=1, oQUERY_FLAGS_VALID=0, oQUERY_FLAGS=0.
REQ-021 Reset asserted mid-operation SHALL discard all state, including DONE entries awaiting commit.

Verification
REQ-022 Dual allocation (defaults, after reset): REGIST_0 with tag 5 and REGIST_1 with tag 6 -> entries 0 and 1 in WAIT; free count 14; REGNAME outputs become 2 and 3.
REQ-023 CDB with both channels matching: channel 0 and channel 1 both carry tag 5 with flags 0x0A and 0x15 in the same cycle -> entry 0 DONE with flags 0x0A; query 0 gives VALID=1, FLAGS=0x0A.
REQ-024 Commit and wrap: entry holding tag 63 in DONE, pulse iCOMMIT_VECTOR bit 0 -> RELEASE next cycle (query VALID=0), FREE one cycle later, free count +1.
REQ-025 Flush: one WAIT entry and one DONE entry, assert iREMOVE_VALID in the same cycle as a matching CDB for the WAIT tag -> WAIT entry becomes FREE with flags unchanged; DONE entry stays DONE.
REQ-026 Full table: allocate all 16 entries -> both READY=0; any further requests are ignored; releasing one entry raises oREGIST_0_READY only from the cycle after it reaches FREE.

Source files
------------

// File: rtl/flag_rename_table.sv
// Flag rename table: allocates entries to flag producers, captures result flags, frees on commit.
// Latency: grant/capture/commit take effect one cycle after the request; lookups are combinational.
// Backpressure: REGIST READY drops when fewer than one/two entries are FREE; requests without READY are dropped.
module flag_rename_table #(
    parameter int ENTRY_N = 16,
    parameter int TAG_W   = 6,
    parameter int FLAG_W  = 5,
    parameter int CDB_N   = 2,
    parameter int IDX_W   = $clog2(ENTRY_N)
) (
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    input  logic                      iREMOVE_VALID,
    input  logic [(1<<TAG_W)-1:0]     iCOMMIT_VECTOR,
    input  logic                      iREGIST_0_VALID,
    input  logic                      iREGIST_1_VALID,
    input  logic [TAG_W-1:0]          iREGIST_0_COMMIT_TAG,
    input  logic [TAG_W-1:0]          iREGIST_1_COMMIT_TAG,
    output logic [IDX_W-1:0]          oREGIST_0_REGNAME,
    output logic [IDX_W-1:0]          oREGIST_1_REGNAME,
    output logic                      oREGIST_0_READY,
    output logic                      oREGIST_1_READY,
    input  logic [CDB_N-1:0]          iCDB_VALID,
    input  logic [CDB_N*TAG_W-1:0]    iCDB_COMMIT_TAG,
    input  logic [CDB_N*FLAG_W-1:0]   iCDB_FLAGS,
    input  logic [IDX_W-1:0]          iQUERY_REGNAME,
    output logic                      oQUERY_FLAGS_VALID,
    output logic [FLAG_W-1:0]         oQUERY_FLAGS,
    output logic [IDX_W:0]            oINFO_FREE_COUNT
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    typedef struct packed {
        state_e              st;
        logic [TAG_W-1:0]    tag;
        logic [FLAG_W-1:0]   flags;
    } entry_t;

    localparam logic [IDX_W:0]   CNT_ONE = 1;
    localparam logic [IDX_W:0]   CNT_TWO = 2;
    localparam logic [TAG_W-1:0] TAG_ONE = 1;

    entry_t entry_q [ENTRY_N];
    entry_t entry_d [ENTRY_N];

    logic [IDX_W:0]    free_cnt;
    logic [IDX_W-1:0]  idx0;
    logic [IDX_W-1:0]  idx1;
    logic              found0;
    logic              found1;
    logic              ready0;
    logic              ready1;
    logic              grant0;
    logic              grant1;

    logic [TAG_W-1:0]  cdb_tag   [CDB_N];
    logic [FLAG_W-1:0] cdb_flags [CDB_N];

    // Free-list scan works purely on registered state, so an entry freed this
    // cycle only becomes grantable once its FREE state is visible next cycle.
    always_comb begin
        free_cnt = '0;
        idx0     = '0;
        idx1     = '0;
        found0   = 1'b0;
        found1   = 1'b0;
        for (int i = 0; i < ENTRY_N; i++) begin
            if (entry_q[i].st == ST_FREE) begin
                free_cnt = free_cnt + CNT_ONE;
                if (!found0) begin
                    found0 = 1'b1;
                    idx0   = IDX_W'(i);
                end else if (!found1) begin
                    found1 = 1'b1;
                    idx1   = IDX_W'(i);
                end
            end
        end
    end

    assign ready0 = (free_cnt >= CNT_ONE);
    assign ready1 = (free_cnt >= CNT_TWO);
    assign grant0 = iREGIST_0_VALID && ready0 && !iREMOVE_VALID;
    assign grant1 = iREGIST_0_VALID && iREGIST_1_VALID && ready1 && !iREMOVE_VALID;

    always_comb begin
        for (int c = 0; c < CDB_N; c++) begin
            cdb_tag[c]   = iCDB_COMMIT_TAG[c*TAG_W +: TAG_W];
            cdb_flags[c] = iCDB_FLAGS[c*FLAG_W +: FLAG_W];
        end
    end

    always_comb begin
        logic              hit;
        logic [FLAG_W-1:0] hit_flags;
        logic [TAG_W-1:0]  commit_idx;
        hit        = 1'b0;
        hit_flags  = '0;
        commit_idx = '0;
        for (int i = 0; i < ENTRY_N; i++) begin
            entry_d[i] = entry_q[i];
            // The commit strobe for a tag arrives on the next tag's bit, wrapping at the top.
            commit_idx = entry_q[i].tag + TAG_ONE;
            hit        = 1'b0;
            hit_flags  = '0;
            case (entry_q[i].st)
                ST_FREE: begin
                    if (grant0 && (idx0 == IDX_W'(i))) begin
                        entry_d[i].st  = ST_WAIT;
                        entry_d[i].tag = iREGIST_0_COMMIT_TAG;
                    end else if (grant1 && (idx1 == IDX_W'(i))) begin
                        entry_d[i].st  = ST_WAIT;
                        entry_d[i].tag = iREGIST_1_COMMIT_TAG;
                    end
                end
                ST_WAIT: begin
                    if (iREMOVE_VALID) begin
                        entry_d[i].st = ST_FREE;
                    end else begin
                        // Descending scan so the lowest matching channel wins.
                        for (int c = CDB_N - 1; c >= 0; c--) begin
                            if (iCDB_VALID[c] && (cdb_tag[c] == entry_q[i].tag)) begin
                                hit       = 1'b1;
                                hit_flags = cdb_flags[c];
                            end
                        end
                        if (hit) begin
                            entry_d[i].st    = ST_DONE;
                            entry_d[i].flags = hit_flags;
                        end
                    end
                end
                ST_DONE: begin
                    if (iCOMMIT_VECTOR[commit_idx]) begin
                        entry_d[i].st = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    entry_d[i].st = ST_FREE;
                end
                default: begin
                    entry_d[i].st = ST_FREE;
                end
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < ENTRY_N; i++) begin
                entry_q[i] <= '{st: ST_FREE, tag: '0, flags: '0};
            end
        end else begin
            for (int i = 0; i < ENTRY_N; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign oREGIST_0_REGNAME  = idx0;
    assign oREGIST_1_REGNAME  = idx1;
    assign oREGIST_0_READY    = ready0;
    assign oREGIST_1_READY    = ready1;
    assign oINFO_FREE_COUNT   = free_cnt;
    assign oQUERY_FLAGS_VALID = (entry_q[iQUERY_REGNAME].st == ST_DONE);
    assign oQUERY_FLAGS       = entry_q[iQUERY_REGNAME].flags;

endmodule

// File: tb/tb_flag_rename_table.sv
// Bench for flag_rename_table: vector table applied per cycle, expectations queued and popped after each edge.
module tb_flag_rename_table;

    logic        clk;
    logic        rst_n;
    logic        rm;
    logic [63:0] cv;
    logic        r0v, r1v;
    logic [5:0]  r0t, r1t;
    logic [3:0]  rn0, rn1;
    logic        rdy0, rdy1;
    logic [1:0]  cdv;
    logic [11:0] cdt;
    logic [9:0]  cdf;
    logic [3:0]  qn;
    logic        qv;
    logic [4:0]  qf;
    logic [4:0]  fcnt;

    flag_rename_table dut (
        .iCLOCK               (clk),
        .inRESET              (rst_n),
        .iREMOVE_VALID        (rm),
        .iCOMMIT_VECTOR       (cv),
        .iREGIST_0_VALID      (r0v),
        .iREGIST_1_VALID      (r1v),
        .iREGIST_0_COMMIT_TAG (r0t),
        .iREGIST_1_COMMIT_TAG (r1t),
        .oREGIST_0_REGNAME    (rn0),
        .oREGIST_1_REGNAME    (rn1),
        .oREGIST_0_READY      (rdy0),
        .oREGIST_1_READY      (rdy1),
        .iCDB_VALID           (cdv),
        .iCDB_COMMIT_TAG      (cdt),
        .iCDB_FLAGS           (cdf),
        .iQUERY_REGNAME       (qn),
        .oQUERY_FLAGS_VALID   (qv),
        .oQUERY_FLAGS         (qf),
        .oINFO_FREE_COUNT     (fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rm;
        logic [63:0] cv;
        logic        v0, v1;
        logic [5:0]  t0, t1;
        logic [1:0]  cdv;
        logic [5:0]  ct0, ct1;
        logic [4:0]  cf0, cf1;
        logic [3:0]  q;
        int          e_cnt, e_rn0, e_rn1, e_qv, e_qf;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t row(string nm, int q, int cnt, int e0, int e1, int eqv, int eqf);
        vec_t v;
        v.nm = nm; v.rm = 1'b0; v.cv = '0;
        v.v0 = 1'b0; v.v1 = 1'b0; v.t0 = '0; v.t1 = '0;
        v.cdv = '0; v.ct0 = '0; v.ct1 = '0; v.cf0 = '0; v.cf1 = '0;
        v.q = 4'(q);
        v.e_cnt = cnt; v.e_rn0 = e0; v.e_rn1 = e1; v.e_qv = eqv; v.e_qf = eqf;
        return v;
    endfunction

    function automatic vec_t al(vec_t v, logic a0, int t0, logic a1, int t1);
        v.v0 = a0; v.t0 = 6'(t0); v.v1 = a1; v.t1 = 6'(t1);
        return v;
    endfunction

    function automatic vec_t cd(vec_t v, logic [1:0] m, int t0, int f0, int t1, int f1);
        v.cdv = m; v.ct0 = 6'(t0); v.cf0 = 5'(f0); v.ct1 = 6'(t1); v.cf1 = 5'(f1);
        return v;
    endfunction

    function automatic vec_t cm(vec_t v, int b);
        v.cv[b] = 1'b1;
        return v;
    endfunction

    function automatic vec_t fl(vec_t v);
        v.rm = 1'b1;
        return v;
    endfunction

    task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
        end
    endtask

    task automatic check_outs(string nm, int cnt, int e0, int e1, int eqv, int eqf);
        chk(nm, "free_count", 32'(fcnt), 32'(cnt));
        chk(nm, "regname0",   32'(rn0),  32'(e0));
        chk(nm, "regname1",   32'(rn1),  32'(e1));
        chk(nm, "ready0",     32'(rdy0), (cnt >= 1) ? 32'd1 : 32'd0);
        chk(nm, "ready1",     32'(rdy1), (cnt >= 2) ? 32'd1 : 32'd0);
        chk(nm, "query_vld",  32'(qv),   32'(eqv));
        chk(nm, "query_flg",  32'(qf),   32'(eqf));
    endtask

    task automatic drive(vec_t v);
        rm  = v.rm;  cv  = v.cv;
        r0v = v.v0;  r0t = v.t0;  r1v = v.v1;  r1t = v.t1;
        cdv = v.cdv; cdt = {v.ct1, v.ct0}; cdf = {v.cf1, v.cf0};
        qn  = v.q;
    endtask

    task automatic apply(vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outs(e.nm, e.e_cnt, e.e_rn0, e.e_rn1, e.e_qv, e.e_qf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected state after each edge; comments track the table contents.
        tbl.push_back(al(row("dual_alloc", 0, 14, 2, 3, 0, 0), 1'b1, 5, 1'b1, 6));
        tbl.push_back(cd(row("cdb_both_match", 0, 14, 2, 3, 1, 'h0A), 2'b11, 5, 'h0A, 5, 'h15));
        tbl.push_back(cd(row("cdb_ch1_only", 1, 14, 2, 3, 1, 'h13), 2'b10, 6, 'h1F, 6, 'h13));
        tbl.push_back(cd(row("cdb_no_owner", 1, 14, 2, 3, 1, 'h13), 2'b11, 9, 'h1F, 9, 'h1F));
        tbl.push_back(cm(row("commit_wrong_bit", 0, 14, 2, 3, 1, 'h0A), 5));
        tbl.push_back(cm(row("commit_release", 0, 14, 2, 3, 0, 'h0A), 6));
        tbl.push_back(row("release_to_free", 0, 15, 0, 2, 0, 'h0A));
        tbl.push_back(al(row("port1_alone", 0, 15, 0, 2, 0, 'h0A), 1'b0, 7, 1'b1, 7));
        tbl.push_back(al(row("alloc_tag63", 0, 14, 2, 3, 0, 'h0A), 1'b1, 63, 1'b0, 0));
        tbl.push_back(cd(row("cdb_tag63", 0, 14, 2, 3, 1, 'h11), 2'b01, 63, 'h11, 0, 0));
        tbl.push_back(cm(row("commit_wrap", 0, 14, 2, 3, 0, 'h11), 0));
        tbl.push_back(row("wrap_free", 0, 15, 0, 2, 0, 'h11));
        tbl.push_back(al(row("alloc_tag20", 0, 14, 2, 3, 0, 'h11), 1'b1, 20, 1'b0, 0));
        tbl.push_back(fl(al(cd(row("flush_vs_cdb", 0, 15, 0, 2, 0, 'h11), 2'b01, 20, 'h05, 0, 0), 1'b1, 30, 1'b0, 0)));
        tbl.push_back(row("done_survives_flush", 1, 15, 0, 2, 1, 'h13));
        tbl.push_back(fl(cm(row("flush_with_commit", 1, 15, 0, 2, 0, 'h13), 7)));
        tbl.push_back(row("all_free", 1, 16, 0, 1, 0, 'h13));

        // Fill: pairs into entries 0..13 with tags 32..45.
        for (int k = 0; k < 7; k++) begin
            tbl.push_back(al(row($sformatf("fill_pair%0d", k), 15, 14 - 2*k, 2*k + 2, 2*k + 3, 0, 0),
                             1'b1, 32 + 2*k, 1'b1, 33 + 2*k));
        end
        tbl.push_back(al(row("fill_single", 15, 1, 15, 0, 0, 0), 1'b1, 46, 1'b0, 0));
        tbl.push_back(al(row("last_one_port1_drop", 15, 0, 0, 0, 0, 0), 1'b1, 47, 1'b1, 48));
        tbl.push_back(al(row("full_ignored", 15, 0, 0, 0, 0, 0), 1'b1, 49, 1'b1, 50));
        tbl.push_back(cd(row("full_cdb_e3", 3, 0, 0, 0, 1, 'h1E), 2'b01, 35, 'h1E, 0, 0));
        tbl.push_back(cm(row("full_commit_e3", 3, 0, 0, 0, 0, 'h1E), 36));
        tbl.push_back(al(row("no_grant_while_release", 3, 1, 3, 0, 0, 'h1E), 1'b1, 51, 1'b0, 0));
        tbl.push_back(al(row("regrant_e3", 3, 0, 0, 0, 0, 'h1E), 1'b1, 52, 1'b0, 0));
        tbl.push_back(cd(row("done_before_reset", 5, 0, 0, 0, 1, 'h07), 2'b01, 37, 'h07, 0, 0));

        rst_n = 1'b0;
        drive(row("idle", 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("reset_state", 16, 0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Asynchronous reset mid-operation, observed before any clock edge.
        @(negedge clk);
        drive(row("idle", 5, 0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_reset_mid_op", 16, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(al(row("alloc_after_reset", 0, 15, 1, 2, 0, 0), 1'b1, 3, 1'b0, 0));

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
